// File: rtl/i2s_encoder_pkg.sv
// Audio-link definitions shared by the I2S encoder and the matching decoder:
// frame layout constants, the stereo sample type and the frame builder.
package i2s_encoder_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 40;
  localparam int IDX_W      = $clog2(FRAME_BITS);

  localparam logic [7:0]       SYNC_WORD = 8'hAA;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BITS - 1);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_t;

  function automatic logic [FRAME_BITS-1:0] build_frame(input stereo_t s);
    return {SYNC_WORD, s.left, s.right};
  endfunction

endpackage

// File: rtl/i2s_encoder_sck_gen.sv
// Bit-clock divider: toggles sck every HALF_PERIOD clk cycles and flags the
// cycle on which sck is about to rise or fall.
module i2s_encoder_sck_gen #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              DIV_W    = $clog2(HALF_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sck_q, sck_d;
  logic             tick;

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    sck_d     = tick ? ~sck_q : sck_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
    end
  end

  assign sck_o  = sck_q;
  assign rise_o = tick & ~sck_q;
  assign fall_o = tick & sck_q;

endmodule

// File: rtl/i2s_encoder.sv
// Serial audio encoder: back-to-back 40-bit frames (sync byte, left, right),
// fed through a one-sample holding register; repeats the last sample on underrun.
module i2s_encoder
  import i2s_encoder_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                sck,
  output logic                sd,
  output logic                frame_start,
  output logic                underrun
);

  logic sck_fall;
  logic sck_rise_unused;

  stereo_t               hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  stereo_t               last_q, last_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q, underrun_d;
  logic                  accept;
  stereo_t               load_src;

  i2s_encoder_sck_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_sck_gen (
    .clk_i (clk),
    .rst_i (rst),
    .sck_o (sck),
    .rise_o(sck_rise_unused),
    .fall_o(sck_fall)
  );

  always_comb begin
    accept        = sample_valid & ~hold_full_q;
    load_src      = last_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    last_d        = last_q;
    shift_d       = shift_q;
    bit_idx_d     = bit_idx_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    if (accept) begin
      hold_d      = {left_in, right_in};
      hold_full_d = 1'b1;
    end

    if (sck_fall) begin
      // An accept coinciding with an empty-register load only primes the next frame.
      if (bit_idx_q == LAST_IDX) begin
        if (hold_full_q) begin
          load_src    = hold_q;
          hold_full_d = 1'b0;
        end else begin
          underrun_d = 1'b1;
        end
        last_d        = load_src;
        shift_d       = build_frame(load_src);
        bit_idx_d     = '0;
        frame_start_d = 1'b1;
      end else begin
        shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
        bit_idx_d = bit_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      last_q        <= '0;
      shift_q       <= '0;
      bit_idx_q     <= LAST_IDX;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      last_q        <= last_d;
      shift_q       <= shift_d;
      bit_idx_q     <= bit_idx_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sample_ready = ~hold_full_q;
  assign sd           = shift_q[FRAME_BITS-1];
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_encoder.sv
// Self-checking bench for i2s_encoder: two instances (HALF_PERIOD 4 and 2) share
// stimulus; a behavioural monitor decodes sd on sck rises and tracks frame timing.
module tb_i2s_encoder;

  localparam int HP_A = 4;
  localparam int HP_B = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] leftIn, rightIn;
  logic        sampleValid;
  logic        readyA, sckA, sdA, fsA, urA;
  logic        readyB, sckB, sdB, fsB, urB;

  always #5 clk = ~clk;

  i2s_encoder #(.HALF_PERIOD(HP_A)) dutA (
    .clk(clk), .rst(rst), .left_in(leftIn), .right_in(rightIn),
    .sample_valid(sampleValid), .sample_ready(readyA), .sck(sckA), .sd(sdA),
    .frame_start(fsA), .underrun(urA)
  );

  i2s_encoder #(.HALF_PERIOD(HP_B)) dutB (
    .clk(clk), .rst(rst), .left_in(leftIn), .right_in(rightIn),
    .sample_valid(sampleValid), .sample_ready(readyB), .sck(sckB), .sd(sdB),
    .frame_start(fsB), .underrun(urB)
  );

  int errors = 0;
  int checks = 0;

  // Monitor state: which instance is observed, and what the reference decoder saw.
  int          sel = 0;
  int          hp = HP_A;
  int          cyc = 0;
  logic        prevSck = 1'b0, prevSd = 1'b0;
  logic        obsSck, obsSd, obsFs, obsUr, obsReady;
  logic [39:0] rxShift = '0;
  int          rxCount = 0;
  int          sckErr = 0, sdGlitch = 0;
  logic [39:0] rxFrames[$];
  int          fsCycles[$];
  logic        urFlags[$];

  // Advance one clk, sample at the falling edge, and update the reference decoder:
  // sck must equal (cycles since reset / HP) mod 2; sd may change only as sck falls.
  task automatic step();
    logic rstAtEdge;
    @(posedge clk);
    rstAtEdge = rst;
    @(negedge clk);
    obsSck   = (sel == 0) ? sckA : sckB;
    obsSd    = (sel == 0) ? sdA : sdB;
    obsFs    = (sel == 0) ? fsA : fsB;
    obsUr    = (sel == 0) ? urA : urB;
    obsReady = (sel == 0) ? readyA : readyB;
    if (rstAtEdge) begin
      cyc     = 0;
      rxCount = 0;
    end else begin
      cyc++;
      if (obsSck !== 1'((cyc / hp) % 2)) sckErr++;
      if (obsSd !== prevSd && !(prevSck === 1'b1 && obsSck === 1'b0)) sdGlitch++;
      if (prevSck === 1'b0 && obsSck === 1'b1) begin
        rxShift = {rxShift[38:0], obsSd};
        rxCount++;
        if (rxCount == 40) rxFrames.push_back(rxShift);
      end
      if (obsFs === 1'b1) begin
        rxCount = 0;
        fsCycles.push_back(cyc);
        urFlags.push_back(obsUr);
      end
    end
    prevSck = obsSck;
    prevSd  = obsSd;
  endtask

  task automatic clearMon();
    rxFrames.delete();
    fsCycles.delete();
    urFlags.delete();
    sckErr   = 0;
    sdGlitch = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sampleValid = 1'b0; leftIn = '0; rightIn = '0;
    repeat (3) step();
    checks++; if (sckA !== 1'b0)   begin errors++; $display("[TB] FAIL reset_sck: got %b want 0", sckA); end
    checks++; if (sdA !== 1'b0)    begin errors++; $display("[TB] FAIL reset_sd: got %b want 0", sdA); end
    checks++; if (fsA !== 1'b0)    begin errors++; $display("[TB] FAIL reset_frame_start: got %b want 0", fsA); end
    checks++; if (urA !== 1'b0)    begin errors++; $display("[TB] FAIL reset_underrun: got %b want 0", urA); end
    checks++; if (readyA !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", readyA); end
    checks++; if (sckB !== 1'b0 || sdB !== 1'b0 || readyB !== 1'b1)
      begin errors++; $display("[TB] FAIL reset_hp2: got sck=%b sd=%b ready=%b want 0 0 1", sckB, sdB, readyB); end
  endtask

  task automatic test_first_frame();
    int          gotFs;
    logic        gotUr;
    logic [39:0] gotFrame;
    clearMon();
    leftIn = 16'h1234; rightIn = 16'hABCD; sampleValid = 1'b1; rst = 1'b0;
    step();
    sampleValid = 1'b0;
    checks++; if (obsReady !== 1'b0) begin errors++; $display("[TB] FAIL ready_after_accept: got %b want 0", obsReady); end
    for (int i = 0; i < 600 && rxFrames.size() < 1; i++) step();
    gotFs    = (fsCycles.size() > 0) ? fsCycles[0] : -1;
    gotUr    = (urFlags.size() > 0) ? urFlags[0] : 1'bx;
    gotFrame = (rxFrames.size() > 0) ? rxFrames[0] : 40'hx;
    checks++; if (gotFs !== 2 * HP_A) begin errors++; $display("[TB] FAIL first_frame_start_cycle: got %0d want %0d", gotFs, 2 * HP_A); end
    checks++; if (gotUr !== 1'b0) begin errors++; $display("[TB] FAIL first_underrun: got %b want 0", gotUr); end
    checks++; if (gotFrame !== 40'hAA1234ABCD) begin errors++; $display("[TB] FAIL first_frame_data: got %h want aa1234abcd", gotFrame); end
    checks++; if (sckErr !== 0) begin errors++; $display("[TB] FAIL first_sck_wave: got %0d bad cycles want 0", sckErr); end
    checks++; if (sdGlitch !== 0) begin errors++; $display("[TB] FAIL first_sd_stable: got %0d bad changes want 0", sdGlitch); end
    checks++; if (obsReady !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_load: got %b want 1", obsReady); end
  endtask

  task automatic test_underrun();
    int gotGap;
    clearMon();
    for (int i = 0; i < 1500 && fsCycles.size() < 3; i++) step();
    for (int i = 0; i < 2; i++) begin
      gotGap = (fsCycles.size() > i + 1) ? fsCycles[i+1] - fsCycles[i] : -1;
      checks++; if (gotGap !== 80 * HP_A) begin errors++; $display("[TB] FAIL underrun_frame_gap%0d: got %0d want %0d", i, gotGap, 80 * HP_A); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= urFlags.size() || urFlags[i] !== 1'b1) begin
        errors++; $display("[TB] FAIL underrun_pulse%0d: got %b want 1", i, (i < urFlags.size()) ? urFlags[i] : 1'bx);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= rxFrames.size() || rxFrames[i] !== 40'hAA1234ABCD) begin
        errors++; $display("[TB] FAIL underrun_repeat%0d: got %h want aa1234abcd", i, (i < rxFrames.size()) ? rxFrames[i] : 40'hx);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expQ[$];
    int          accCyc[$];
    int          nAcc;
    clearMon();
    // The frame already in flight repeats the previous sample.
    expQ.push_back({16'h1234, 16'hABCD});
    for (int i = 0; i < 2000 && rxFrames.size() < 5; i++) begin
      leftIn = 16'($urandom); rightIn = 16'($urandom); sampleValid = 1'b1;
      if (obsReady === 1'b1) begin
        expQ.push_back({leftIn, rightIn});
        accCyc.push_back(cyc);
      end
      step();
    end
    sampleValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= rxFrames.size() || i >= expQ.size() || rxFrames[i] !== {8'hAA, expQ[i]}) begin
        errors++;
        $display("[TB] FAIL b2b_frame%0d: got %h want %h", i, (i < rxFrames.size()) ? rxFrames[i] : 40'hx,
                 (i < expQ.size()) ? {8'hAA, expQ[i]} : 40'hx);
      end
    end
    checks++; if (fsCycles.size() < 4) begin errors++; $display("[TB] FAIL b2b_loads: got %0d want >= 4", fsCycles.size()); end
    for (int i = 0; i < urFlags.size(); i++) begin
      checks++; if (urFlags[i] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_underrun%0d: got %b want 0", i, urFlags[i]); end
    end
    for (int i = 0; i + 1 < fsCycles.size(); i++) begin
      nAcc = 0;
      foreach (accCyc[k]) if (accCyc[k] >= fsCycles[i] && accCyc[k] < fsCycles[i+1]) nAcc++;
      checks++; if (nAcc !== 1) begin errors++; $display("[TB] FAIL b2b_accepts_per_frame%0d: got %0d want 1", i, nAcc); end
    end
    checks++; if (sdGlitch !== 0) begin errors++; $display("[TB] FAIL b2b_sd_stable: got %0d bad changes want 0", sdGlitch); end
  endtask

  task automatic test_aa_data();
    int          gotFs;
    logic [39:0] gotFrame;
    sampleValid = 1'b0; rst = 1'b1;
    step(); step();
    clearMon();
    leftIn = 16'hAAAA; rightIn = 16'h00AA; sampleValid = 1'b1; rst = 1'b0;
    step();
    sampleValid = 1'b0;
    for (int i = 0; i < 600 && rxFrames.size() < 1; i++) step();
    gotFs    = (fsCycles.size() > 0) ? fsCycles[0] : -1;
    gotFrame = (rxFrames.size() > 0) ? rxFrames[0] : 40'hx;
    checks++; if (gotFs !== 2 * HP_A) begin errors++; $display("[TB] FAIL aa_frame_start_cycle: got %0d want %0d", gotFs, 2 * HP_A); end
    checks++; if (gotFrame !== 40'hAAAAAA00AA) begin errors++; $display("[TB] FAIL aa_frame_data: got %h want aaaaaa00aa", gotFrame); end
  endtask

  task automatic test_reset_mid();
    int          base, gotFs;
    logic        gotUr;
    logic [39:0] gotFrame;
    for (int i = 0; i < 1000 && rxCount != 20; i++) step();
    base = rxFrames.size();
    rst = 1'b1;
    step();
    checks++; if (obsSck !== 1'b0 || obsSd !== 1'b0)
      begin errors++; $display("[TB] FAIL midreset_outputs: got sck=%b sd=%b want 0 0", obsSck, obsSd); end
    rst = 1'b0;
    fsCycles.delete();
    urFlags.delete();
    for (int i = 0; i < 600 && rxFrames.size() <= base; i++) step();
    gotFs    = (fsCycles.size() > 0) ? fsCycles[0] : -1;
    gotUr    = (urFlags.size() > 0) ? urFlags[0] : 1'bx;
    gotFrame = (rxFrames.size() > base) ? rxFrames[base] : 40'hx;
    checks++; if (gotFs !== 2 * HP_A) begin errors++; $display("[TB] FAIL midreset_frame_start_cycle: got %0d want %0d", gotFs, 2 * HP_A); end
    checks++; if (gotUr !== 1'b1) begin errors++; $display("[TB] FAIL midreset_underrun: got %b want 1", gotUr); end
    checks++; if (gotFrame !== 40'hAA00000000) begin errors++; $display("[TB] FAIL midreset_frame_data: got %h want aa00000000", gotFrame); end
  endtask

  task automatic test_hp2();
    int          gotFs, gotGap;
    logic [39:0] gotFrame;
    sampleValid = 1'b0; rst = 1'b1; sel = 1; hp = HP_B;
    step(); step();
    clearMon();
    leftIn = 16'h8001; rightIn = 16'h7FFE; sampleValid = 1'b1; rst = 1'b0;
    step();
    sampleValid = 1'b0;
    for (int i = 0; i < 600 && fsCycles.size() < 2; i++) step();
    gotFs    = (fsCycles.size() > 0) ? fsCycles[0] : -1;
    gotGap   = (fsCycles.size() > 1) ? fsCycles[1] - fsCycles[0] : -1;
    gotFrame = (rxFrames.size() > 0) ? rxFrames[0] : 40'hx;
    checks++; if (gotFs !== 2 * HP_B) begin errors++; $display("[TB] FAIL hp2_frame_start_cycle: got %0d want %0d", gotFs, 2 * HP_B); end
    checks++; if (gotGap !== 80 * HP_B) begin errors++; $display("[TB] FAIL hp2_frame_gap: got %0d want %0d", gotGap, 80 * HP_B); end
    checks++; if (gotFrame !== 40'hAA80017FFE) begin errors++; $display("[TB] FAIL hp2_frame_data: got %h want aa80017ffe", gotFrame); end
    checks++; if (sckErr !== 0) begin errors++; $display("[TB] FAIL hp2_sck_wave: got %0d bad cycles want 0", sckErr); end
    checks++; if (sdGlitch !== 0) begin errors++; $display("[TB] FAIL hp2_sd_stable: got %0d bad changes want 0", sdGlitch); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_underrun();
    test_back_to_back();
    test_aa_data();
    test_reset_mid();
    test_hp2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_encoder.md
I2S_ENCODER -- requirements
Module: i2s_encoder

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4: clk cycles per sck half-period; legal values are 2 and above.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port left_in, input, 16 bits: left sample, two's complement.
REQ-005 SHALL have port right_in, input, 16 bits: right sample, two's complement.
REQ-006 SHALL have port sample_valid, input, 1 bit: left_in/right_in hold a new stereo sample.
REQ-007 SHALL have port sample_ready, output, 1 bit: the holding register is empty and can accept a sample.
REQ-008 SHALL have port sck, output, 1 bit: serial bit clock.
REQ-009 SHALL have port sd, output, 1 bit: serial data; changes only on sck falling edges.
REQ-010 SHALL have port frame_start, output, 1 bit: one-cycle pulse on the cycle a new frame is loaded.
REQ-011 SHALL have port underrun, output, 1 bit: one-cycle pulse on a frame load that had no new sample available.

Function
REQ-012 SHALL transmit continuous back-to-back 40-bit frames, MSB first: 8'hAA, then left[15:0], then right[15:0].
REQ-013 SHALL run a divider counter div_cnt over 0..HALF_PERIOD-1; when div_cnt equals HALF_PERIOD-1, div_cnt returns to 0 and sck toggles on the same cycle.
REQ-014 SHALL give sck a period of exactly 2*HALF_PERIOD clk cycles with a 50% duty cycle, no gaps between frames.
REQ-015 SHALL update sd only on the cycle sck goes 1->0; sd SHALL stay constant across every sck rising edge.
REQ-016 SHALL keep a bit index bit_idx over 0..39; on each falling edge, if bit_idx is 39, a frame load occurs, otherwise sd takes the next frame bit and bit_idx increments.
REQ-017 Frame load SHALL capture the 40-bit frame into the shift register, drive sd with frame bit 39 (1), set bit_idx to 0, and pulse frame_start.
REQ-018 Frame load source SHALL be the holding register if it is full, which is then emptied; otherwise the last transmitted sample is repeated and underrun pulses.
REQ-019 Handshake: the holding register SHALL capture left_in/right_in on a cycle with sample_valid=1 and sample_ready=1; sample_ready SHALL equal "holding register empty".
REQ-020 Accept on the same cycle as a frame load with the holding register empty: the frame SHALL use the repeated sample and the accepted sample SHALL go to the holding register for the next frame.
REQ-021 sample_valid while sample_ready=0 SHALL be ignored; the held sample is not overwritten.
REQ-022 The 8'hAA sync and contiguous 40-bit framing SHALL satisfy the downstream decoder, which samples sd on sck rising edges through 2-flop synchronizers and re-arms only after at least 40 bits.

Reset
REQ-023 While rst=1 the block SHALL set: sck=0, sd=0, div_cnt=0, bit_idx=39, holding register empty, last sample=0, sample_ready=1, frame_start=0, underrun=0.
REQ-024 After rst deasserts, the first sck rise SHALL occur HALF_PERIOD cycles later, and the first frame load on the first fall, 2*HALF_PERIOD cycles later.
REQ-025 rst asserted mid-frame SHALL abandon the frame immediately, with no partial completion; the downstream decoder discards it because no valid sync completes.

Structure
REQ-026 SHALL take SYNC_WORD=8'hAA, FRAME_BITS=40 and SAMPLE_W=16 from a shared audio-link package also used by the decoder.
REQ-027 SHALL place the sck divider and edge strobes (rise and fall) in one sub-module, sck_gen; framing, shift and handshake logic stay in i2s_encoder.

Verification
REQ-028 Accept left=16'h1234 and right=16'hABCD after reset with HALF_PERIOD=4 -> sd over the first frame is AA1234ABCD, frame_start at cycle 8, and a looped-back decoder outputs 1234/ABCD.
REQ-029 No sample after the first one -> frames repeat 1234/ABCD every 320 cycles, with an underrun pulse on each load.
REQ-030 sample_valid held high continuously -> exactly one accept per frame; sample_ready low between accept and the next load; no sample lost or duplicated.
REQ-031 Sample whose data contains 8'hAA, left=16'hAAAA and right=16'h00AA -> decoder output matches exactly, with no false sync.
REQ-032 rst pulsed at bit 20 of a frame -> sck=0, sd=0 next cycle; first new frame_start 2*HALF_PERIOD cycles after rst drops; decoder outputs only complete frames.
REQ-033 HALF_PERIOD=2 -> sck period 4 cycles, and the decoder still decodes 16'h8001/16'h7FFE correctly.
